// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and
// small decode helpers used by the control and result datapath.
package md_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    function automatic logic is_mul_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational product / quotient / remainder from the latched operands.
// Timing is owned by the caller, so an iterative divider can replace this later.
module md_result_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               b_zero
);

    // Magnitude of a two's-complement value; the most-negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic        [WIDTH-1:0]   b_safe;
    logic        [WIDTH-1:0]   quo_u;
    logic        [WIDTH-1:0]   rem_u;
    logic        [WIDTH-1:0]   mag_a;
    logic        [WIDTH-1:0]   mag_b;
    logic        [WIDTH-1:0]   quo_m;
    logic        [WIDTH-1:0]   rem_m;
    logic        [WIDTH-1:0]   quo_s;
    logic        [WIDTH-1:0]   rem_s;

    assign b_zero = (b == '0);

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Divide by a substitute of 1 when b is zero so no X reaches HI/LO muxes;
    // the control never commits a divide-by-zero result.
    assign b_safe = b_zero ? WIDTH'(1) : b;
    assign quo_u  = a / b_safe;
    assign rem_u  = a % b_safe;

    // Signed divide on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. MIN / -1 wraps back to MIN with rem 0.
    assign mag_a = abs_mag(a);
    assign mag_b = b_zero ? WIDTH'(1) : abs_mag(b);
    assign quo_m = mag_a / mag_b;
    assign rem_m = mag_a % mag_b;
    assign quo_s = neg_if(a[WIDTH-1] ^ b[WIDTH-1], quo_m);
    assign rem_s = neg_if(a[WIDTH-1], rem_m);

    always_comb begin
        hi = '0;
        lo = '0;
        case (op)
            MD_MULT:  {hi, lo} = prod_s;
            MD_MULTU: {hi, lo} = prod_u;
            MD_DIV: begin
                hi = rem_s;
                lo = quo_s;
            end
            MD_DIVU: begin
                hi = rem_u;
                lo = quo_u;
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// busy is held for the full operation latency so later HI/LO users stall.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cancel,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               div_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0]   cnt;
    logic [MD_OP_W-1:0] op_p0;
    logic [WIDTH-1:0]   a_p0;
    logic [WIDTH-1:0]   b_p0;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_b_zero;
    logic               accept;
    logic               finish;

    assign accept = (cnt == '0) && start && !cancel;
    assign finish = (cnt == CNT_W'(1));

    md_result_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op     (op_p0),
        .a      (a_p0),
        .b      (b_p0),
        .hi     (res_hi),
        .lo     (res_lo),
        .b_zero (res_b_zero)
    );

    // Operand latch: only captured on accept, so a/b may change freely while busy.
    always_ff @(posedge clk) begin
        if (accept && (is_mul_op(md_op) || is_div_op(md_op))) begin
            op_p0 <= md_op;
            a_p0  <= a;
            b_p0  <= b;
        end
    end

    // Control and HI/LO: IDLE when cnt==0, RUN otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            div_zero <= 1'b0;
            if (cnt == '0) begin
                if (accept) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            cnt  <= CNT_W'(MULT_CYCLES);
                            busy <= 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            cnt  <= CNT_W'(DIV_CYCLES);
                            busy <= 1'b1;
                        end
                        MD_MTHI: hi <= a;
                        MD_MTLO: lo <= a;
                        default: ;
                    endcase
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
                if (finish) begin
                    busy <= 1'b0;
                    if (is_div_op(op_p0) && res_b_zero) begin
                        div_zero <= 1'b1;
                    end else begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus random
// operations compared against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cancel   (cancel),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: HI/LO after an accepted op, from the arithmetic definition.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                               output logic dz);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        dz = 1'b0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (op)
            3'd0: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, av} * {32'd0, bv};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                if (bv == 0) dz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd3: begin
                if (bv == 0) dz = 1'b1;
                else begin
                    m_lo = av / bv;
                    m_hi = av % bv;
                end
            end
            3'd4: m_hi = av;
            3'd5: m_lo = av;
            default: ;
        endcase
    endtask

    // Issue one op, follow it through its whole latency, and check the outcome.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        int   lat;
        logic dz;
        @(negedge clk);
        start = 1'b1; cancel = 1'b0; md_op = op; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
        if (op > 3'd3) begin
            model_apply(op, av, bv, dz);
            @(negedge clk);
            check("mt_busy", {63'd0, busy}, 64'd0);
            check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
            check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
            return;
        end
        lat = (op < 3'd2) ? 5 : 10;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("run_busy", {63'd0, busy}, 64'd1);
            check("run_hold", {hi, lo}, {m_hi, m_lo});
            a = $urandom; b = $urandom;
        end
        model_apply(op, av, bv, dz);
        @(negedge clk);
        check("done_busy", {63'd0, busy}, 64'd0);
        check("done_hilo", {hi, lo}, {m_hi, m_lo});
        check("done_dz", {63'd0, div_zero}, {63'd0, dz});
        @(negedge clk);
        check("dz_clear", {63'd0, div_zero}, 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        dz;

        reset = 1'b1; start = 1'b0; cancel = 1'b0; md_op = '0; a = '0; b = '0;

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_dz", {63'd0, div_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        // 2. MULT / MULTU
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // 3. DIV / DIVU
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2);
        check("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);

        // 4. preload then divide by zero
        run_op(3'd4, 32'h11, 32'd0);
        run_op(3'd5, 32'h22, 32'd0);
        run_op(3'd3, 32'd7, 32'd0);
        check("dz_hilo_const", {hi, lo}, 64'h0000_0011_0000_0022);

        // overflow case: MIN / -1
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // 5a. start with cancel is ignored
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; md_op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("cancel_busy", {63'd0, busy}, 64'd0);
        end
        check("cancel_hilo", {hi, lo}, {m_hi, m_lo});
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; md_op = 3'd5; a = 32'd77;
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check("cancel_mt", {hi, lo}, {m_hi, m_lo});

        // 5b. MTLO issued while DIV busy is ignored
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'hFFFF_FFF9;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start = 1'b1; md_op = 3'd5; a = 32'd5; b = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        model_apply(3'd2, 32'd100, 32'hFFFF_FFF9, dz);
        @(negedge clk);
        check("busy_mt_result", {hi, lo}, {m_hi, m_lo});
        check("busy_mt_const", {hi, lo}, 64'h0000_0002_FFFF_FFF2);

        // 6. reset mid-DIV aborts the op
        @(negedge clk);
        start = 1'b1; md_op = 3'd3; a = 32'd50; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        check("abort_late", {hi, lo}, 64'd0);
        check("abort_late_busy", {63'd0, busy}, 64'd0);

        // random ops against the model
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9)) | (rb & 32'h8000_0000);
                default: ;
            endcase
            if (rop == 3'd6) begin
                @(negedge clk);
                start = 1'b1; md_op = 3'($urandom_range(6, 7)); a = ra; b = rb;
                @(posedge clk);
                #1 start = 1'b0;
                @(negedge clk);
                check("rand_noop_busy", {63'd0, busy}, 64'd0);
                check("rand_noop_hilo", {hi, lo}, {m_hi, m_lo});
            end else begin
                run_op(rop, ra, rb);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
